rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning byte-entry capacity; SHALL be a power of two and at least 2.
REQ-002 clk  in  1  13.56MHz recovered carrier clock; the only clock.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 fd_soc, fd_eoc  in  1 each  start-of-comms and end-of-comms pulses from the frame decoder.
REQ-005 fd_data  in  8, and fd_data_bits  in  3  decoded byte and its valid bit count (0 means 8 bits).
REQ-006 fd_data_valid, fd_sequence_error, fd_parity_error  in  1 each  decoder strobes.
REQ-007 rx_data  out  8, and rx_data_bits  out  3  head-of-FIFO byte and its bit count.
REQ-008 rx_valid  out  1, rx_last  out  1, rx_ready  in  1  valid/ready byte stream to the upper layer.
REQ-009 frame_len  out  $clog2(FIFO_DEPTH)+1  byte count of the current frame.
REQ-010 frame_done  out  1, frame_error  out  1, error_code  out  RxError, rx_abort  out  1  one-cycle status pulses.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, RX, DRAIN.
REQ-013 IDLE: fd_soc -> RX next cycle; clear FIFO, frame_len and sticky errors. fd_eoc, fd_data_valid and error strobes are ignored in IDLE.
REQ-014 RX, fd_data_valid: push {fd_data, fd_data_bits} and increment frame_len. If the FIFO is full, drop the byte and set sticky OVERFLOW.
REQ-015 RX, fd_sequence_error: set sticky SEQUENCE. RX, fd_parity_error: set sticky PARITY.
REQ-016 RX, fd_eoc: all same-cycle strobes are applied first, so a broken final byte or an error flagged with EOC is included.
REQ-017 RX, fd_eoc, no sticky error and frame_len>0: go to DRAIN next cycle.
REQ-018 RX, fd_eoc, error present or frame_len==0: flush the FIFO, return to IDLE, and pulse frame_error with error_code for one cycle.
REQ-019 error_code priority: OVERFLOW > PARITY > SEQUENCE > EMPTY. error_code holds its value until the next frame_error.
REQ-020 Store-and-forward: rx_valid SHALL be 0 outside DRAIN.
REQ-021 DRAIN: rx_valid = FIFO non-empty. rx_data and rx_data_bits show the head entry. rx_last = exactly one entry remains.
REQ-022 A transfer occurs when rx_valid and rx_ready are both high at a clock edge; the head is popped at that edge.
REQ-023 While rx_valid is high and rx_ready is low, rx_data, rx_data_bits and rx_last SHALL hold.
REQ-024 When the rx_last entry transfers: pulse frame_done the next cycle and go to IDLE.
REQ-025 frame_len SHALL hold through DRAIN and through the frame_done cycle.
REQ-026 fd_soc in RX or DRAIN: flush the FIFO, pulse rx_abort, and restart RX as in REQ-013. No frame_done or frame_error is issued for the aborted frame.
REQ-027 Exactly full FIFO (FIFO_DEPTH bytes) with no further push is not an overflow and drains normally.
REQ-028 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the full/empty distinction uses an extra pointer bit.
REQ-029 Latency: fd_eoc at edge N -> rx_valid high at N+1, or frame_error high at N+1.

Reset
REQ-030 On rst_n low: state IDLE, FIFO empty, frame_len=0, error_code=RxError_NONE.
REQ-031 On rst_n low: rx_valid, rx_last, frame_done, frame_error, rx_abort and busy = 0.
REQ-032 On rst_n low: rx_data=0 and rx_data_bits=0.
REQ-033 Reset mid-frame or mid-drain SHALL discard all data silently.

Structure
REQ-034 The enum RxError {NONE, SEQUENCE, PARITY, OVERFLOW, EMPTY} SHALL live in ISO14443A_pkg.
REQ-035 The FSM state enum SHALL be local to the module.
REQ-036 Storage SHALL be one sub-module, rx_byte_fifo: synchronous 11-bit-wide FIFO with push, pop, flush, full, empty and count.

Verification
REQ-037 Frame of bytes 0x26 then 0x93, rx_ready=1 -> two transfers, rx_last on 0x93, frame_len=2, frame_done pulse, busy returns to 0.
REQ-038 Frame 0x93 0x20 then a 4-bit broken byte 0x5 with eoc on the same cycle as its data_valid -> third entry has data_bits=4 and rx_last=1, frame_len=3.
REQ-039 fd_parity_error on byte 2 of 3 -> no rx_valid, frame_error pulse with error_code=PARITY, FIFO empty afterwards.
REQ-040 FIFO_DEPTH=8 with 9 bytes -> error_code=OVERFLOW; with exactly 8 bytes -> 8 transfers and frame_done.
REQ-041 rx_ready held low 5 cycles in DRAIN -> rx_data stable throughout; new fd_soc during DRAIN -> rx_abort pulse, new frame received correctly.
REQ-042 soc then eoc with no data and no error -> error_code=EMPTY; rst_n asserted mid-RX -> all outputs at reset values, next frame received normally.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// Shared types for the ISO14443A receive path: error codes, FIFO entry layout.
package ISO14443A_pkg;

    localparam int unsigned RX_BYTE_W  = 8;
    localparam int unsigned RX_BITS_W  = 3;
    localparam int unsigned RX_ENTRY_W = RX_BYTE_W + RX_BITS_W;

    typedef enum logic [2:0] {
        RxError_NONE     = 3'd0,
        RxError_SEQUENCE = 3'd1,
        RxError_PARITY   = 3'd2,
        RxError_OVERFLOW = 3'd3,
        RxError_EMPTY    = 3'd4
    } RxError;

    typedef struct packed {
        logic [RX_BYTE_W-1:0] data;
        logic [RX_BITS_W-1:0] bits;
    } rx_entry_t;

    // Highest-priority error wins: OVERFLOW > PARITY > SEQUENCE > EMPTY.
    function automatic RxError rx_error_pick(input logic ovf, input logic par,
                                             input logic seq, input logic empty_frame);
        if (ovf)              return RxError_OVERFLOW;
        else if (par)         return RxError_PARITY;
        else if (seq)         return RxError_SEQUENCE;
        else if (empty_frame) return RxError_EMPTY;
        else                  return RxError_NONE;
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous byte FIFO with flush; the head entry is presented from a register.
module rx_byte_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    wr_q, rd_q, wr_nxt, rd_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             push_ok, pop_ok;

    // Pointer update plus look-ahead of the head so dout can be registered.
    always_comb begin
        push_ok     = push && !full && !flush;
        pop_ok      = pop && !empty && !flush;
        wr_nxt      = flush ? '0 : wr_q + CW'(push_ok);
        rd_nxt      = flush ? '0 : rd_q + CW'(pop_ok);
        count_nxt_c = wr_nxt - rd_nxt;
        if (flush)
            head_nxt = '0;
        else if (push_ok && (wr_q[AW-1:0] == rd_nxt[AW-1:0]))
            head_nxt = din;
        else
            head_nxt = mem[rd_nxt[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            dout  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            count <= '0;
        end else begin
            wr_q  <= wr_nxt;
            rd_q  <= rd_nxt;
            dout  <= head_nxt;
            full  <= (count_nxt_c == CW'(DEPTH));
            empty <= (count_nxt_c == '0);
            count <= count_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: buffers a decoded frame, then forwards it only if error-free.
module rx_frame_ctrl
    import ISO14443A_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          fd_soc,
    input  logic                          fd_eoc,
    input  logic [7:0]                    fd_data,
    input  logic [2:0]                    fd_data_bits,
    input  logic                          fd_data_valid,
    input  logic                          fd_sequence_error,
    input  logic                          fd_parity_error,
    output logic [7:0]                    rx_data,
    output logic [2:0]                    rx_data_bits,
    output logic                          rx_valid,
    output logic                          rx_last,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   frame_len,
    output logic                          frame_done,
    output logic                          frame_error,
    output RxError                        error_code,
    output logic                          rx_abort,
    output logic                          busy
);

    localparam int unsigned LEN_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RX    = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic             ovf_q, ovf_nxt, par_q, par_nxt, seq_q, seq_nxt;
    RxError           code_q, code_nxt;
    logic             valid_q, valid_nxt, last_q, last_nxt;
    logic             done_q, done_nxt, err_q, err_nxt;
    logic             abort_q, abort_nxt, busy_q, busy_nxt;

    logic             fifo_push, fifo_pop, fifo_flush;
    logic             fifo_full, fifo_empty;
    logic [LEN_W-1:0] fifo_count, fifo_count_nxt;
    rx_entry_t        push_entry, head_entry;

    assign push_entry = '{data: fd_data, bits: fd_data_bits};

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RX_ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (fifo_push),
        .din         (push_entry),
        .pop         (fifo_pop),
        .flush       (fifo_flush),
        .dout        (head_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count),
        .count_nxt_c (fifo_count_nxt)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state_q;
        len_nxt    = len_q;
        ovf_nxt    = ovf_q;
        par_nxt    = par_q;
        seq_nxt    = seq_q;
        code_nxt   = code_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        abort_nxt  = 1'b0;

        if (fd_soc) begin
            // A new frame always restarts reception; mid-frame it aborts the old one.
            state_nxt  = S_RX;
            fifo_flush = 1'b1;
            len_nxt    = '0;
            ovf_nxt    = 1'b0;
            par_nxt    = 1'b0;
            seq_nxt    = 1'b0;
            abort_nxt  = (state_q != S_IDLE);
        end else begin
            case (state_q)
                S_RX: begin
                    if (fd_sequence_error) seq_nxt = 1'b1;
                    if (fd_parity_error)   par_nxt = 1'b1;
                    if (fd_data_valid) begin
                        if (fifo_full) begin
                            ovf_nxt = 1'b1;
                        end else begin
                            fifo_push = 1'b1;
                            len_nxt   = len_q + LEN_W'(1);
                        end
                    end
                    // Same-cycle strobes above are already folded in before judging the frame.
                    if (fd_eoc) begin
                        if (ovf_nxt || par_nxt || seq_nxt || (len_nxt == '0)) begin
                            fifo_flush = 1'b1;
                            state_nxt  = S_IDLE;
                            err_nxt    = 1'b1;
                            code_nxt   = rx_error_pick(ovf_nxt, par_nxt, seq_nxt,
                                                       len_nxt == '0);
                        end else begin
                            state_nxt = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (valid_q && rx_ready && !fifo_empty) begin
                        fifo_pop = 1'b1;
                        if (fifo_count == LEN_W'(1)) begin
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                S_IDLE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        valid_nxt = (state_nxt == S_DRAIN) && (fifo_count_nxt != '0);
        last_nxt  = (state_nxt == S_DRAIN) && (fifo_count_nxt == LEN_W'(1));
        busy_nxt  = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            par_q   <= 1'b0;
            seq_q   <= 1'b0;
            code_q  <= RxError_NONE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            len_q   <= len_nxt;
            ovf_q   <= ovf_nxt;
            par_q   <= par_nxt;
            seq_q   <= seq_nxt;
            code_q  <= code_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            abort_q <= abort_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign rx_data      = head_entry.data;
    assign rx_data_bits = head_entry.bits;
    assign rx_valid     = valid_q;
    assign rx_last      = last_q;
    assign frame_len    = len_q;
    assign frame_done   = done_q;
    assign frame_error  = err_q;
    assign error_code   = code_q;
    assign rx_abort     = abort_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a scoreboard of expected transfers, lengths and errors.
module tb_rx_frame_ctrl;
    import ISO14443A_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] b;
        logic       l;
    } exp_t;

    logic       clk, rst_n;
    logic       fd_soc, fd_eoc, fd_data_valid, fd_sequence_error, fd_parity_error;
    logic [7:0] fd_data;
    logic [2:0] fd_data_bits;
    logic [7:0] rx_data;
    logic [2:0] rx_data_bits;
    logic       rx_valid, rx_last, rx_ready;
    logic [3:0] frame_len;
    logic       frame_done, frame_error, rx_abort, busy;
    RxError     error_code;

    int n_cmp = 0;
    int n_fail = 0;
    int valid_cycles = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int abort_cnt = 0;
    int vc_save;

    exp_t       exp_q[$];
    logic [3:0] len_q[$];
    RxError     errq[$];
    exp_t       mon_e;

    rx_frame_ctrl #(.FIFO_DEPTH(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fd_soc            (fd_soc),
        .fd_eoc            (fd_eoc),
        .fd_data           (fd_data),
        .fd_data_bits      (fd_data_bits),
        .fd_data_valid     (fd_data_valid),
        .fd_sequence_error (fd_sequence_error),
        .fd_parity_error   (fd_parity_error),
        .rx_data           (rx_data),
        .rx_data_bits      (rx_data_bits),
        .rx_valid          (rx_valid),
        .rx_last           (rx_last),
        .rx_ready          (rx_ready),
        .frame_len         (frame_len),
        .frame_done        (frame_done),
        .frame_error       (frame_error),
        .error_code        (error_code),
        .rx_abort          (rx_abort),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // One decoder cycle: strobes applied for exactly one rising edge.
    task automatic drive(input logic soc, input logic eoc, input logic dv, input logic [7:0] d,
                         input logic [2:0] b, input logic seq, input logic par);
        fd_soc = soc; fd_eoc = eoc; fd_data_valid = dv; fd_data = d; fd_data_bits = b;
        fd_sequence_error = seq; fd_parity_error = par;
        @(posedge clk); #1;
        fd_soc = 1'b0; fd_eoc = 1'b0; fd_data_valid = 1'b0; fd_data = 8'h00;
        fd_data_bits = 3'd0; fd_sequence_error = 1'b0; fd_parity_error = 1'b0;
    endtask

    task automatic soc();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic eoc_only();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic byte_in(input logic [7:0] d, input logic [2:0] b, input logic eoc,
                           input logic par, input logic seq);
        drive(1'b0, eoc, 1'b1, d, b, seq, par);
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic [2:0] b, input logic l);
        exp_t e;
        e.d = d; e.b = b; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_within_budget", 32'(i < budget), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_valid",     32'(rx_valid),     32'd0);
        check("rst_rx_last",      32'(rx_last),      32'd0);
        check("rst_frame_done",   32'(frame_done),   32'd0);
        check("rst_frame_error",  32'(frame_error),  32'd0);
        check("rst_rx_abort",     32'(rx_abort),     32'd0);
        check("rst_busy",         32'(busy),         32'd0);
        check("rst_rx_data",      32'(rx_data),      32'd0);
        check("rst_rx_data_bits", 32'(rx_data_bits), 32'd0);
        check("rst_frame_len",    32'(frame_len),    32'd0);
        check("rst_error_code",   32'(error_code),   32'(RxError_NONE));
    endtask

    // Output monitor: pops the scoreboard on every transfer and status pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("xfer_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("xfer_data", 32'(rx_data),      32'(mon_e.d));
                    check("xfer_bits", 32'(rx_data_bits), 32'(mon_e.b));
                    check("xfer_last", 32'(rx_last),      32'(mon_e.l));
                end
            end
            if (frame_done) begin
                done_cnt++;
                if (len_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else check("frame_len", 32'(frame_len), 32'(len_q.pop_front()));
            end
            if (frame_error) begin
                err_cnt++;
                if (errq.size() == 0) check("error_unexpected", 32'd1, 32'd0);
                else check("error_code", 32'(error_code), 32'(errq.pop_front()));
            end
            if (rx_abort) abort_cnt++;
        end
    end

    initial begin
        rst_n = 1'b0; rx_ready = 1'b1;
        fd_soc = 1'b0; fd_eoc = 1'b0; fd_data_valid = 1'b0; fd_data = 8'h00;
        fd_data_bits = 3'd0; fd_sequence_error = 1'b0; fd_parity_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-byte frame, EOC on its own cycle
        soc();
        expect_byte(8'h26, 3'd0, 1'b0);
        expect_byte(8'h93, 3'd0, 1'b1);
        len_q.push_back(4'd2);
        byte_in(8'h26, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h93, 3'd0, 1'b0, 1'b0, 1'b0);
        eoc_only();
        check("t1_valid_latency", 32'(rx_valid), 32'd1);
        wait_idle(50);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Broken 4-bit final byte with EOC in the same cycle
        soc();
        expect_byte(8'h93, 3'd0, 1'b0);
        expect_byte(8'h20, 3'd0, 1'b0);
        expect_byte(8'h05, 3'd4, 1'b1);
        len_q.push_back(4'd3);
        byte_in(8'h93, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h20, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h05, 3'd4, 1'b1, 1'b0, 1'b0);
        check("t2_valid_latency", 32'(rx_valid), 32'd1);
        wait_idle(50);
        check("t2_done_cnt", 32'(done_cnt), 32'd2);

        // Parity error on byte 2 of 3: frame dropped
        vc_save = valid_cycles;
        soc();
        errq.push_back(RxError_PARITY);
        byte_in(8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h22, 3'd0, 1'b0, 1'b1, 1'b0);
        byte_in(8'h33, 3'd0, 1'b1, 1'b0, 1'b0);
        check("t3_error_latency", 32'(frame_error), 32'd1);
        check("t3_no_valid_now", 32'(rx_valid), 32'd0);
        wait_idle(50);
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_valid_cycles", 32'(valid_cycles), 32'(vc_save));
        check("t3_code_held", 32'(error_code), 32'(RxError_PARITY));

        // Sequence error only
        soc();
        errq.push_back(RxError_SEQUENCE);
        byte_in(8'h44, 3'd0, 1'b0, 1'b0, 1'b1);
        eoc_only();
        check("t3b_error_latency", 32'(frame_error), 32'd1);
        wait_idle(50);

        // Exactly full FIFO drains normally
        soc();
        for (int i = 0; i < 8; i++) begin
            expect_byte(8'(i * 17 + 1), 3'd0, 1'(i == 7));
            byte_in(8'(i * 17 + 1), 3'd0, 1'(i == 7), 1'b0, 1'b0);
        end
        len_q.push_back(4'd8);
        check("t4_valid_latency", 32'(rx_valid), 32'd1);
        wait_idle(100);
        check("t4_done_cnt", 32'(done_cnt), 32'd3);
        check("t4_code_held", 32'(error_code), 32'(RxError_SEQUENCE));

        // Nine bytes overflow an 8-deep FIFO
        soc();
        errq.push_back(RxError_OVERFLOW);
        for (int i = 0; i < 9; i++) byte_in(8'(i + 100), 3'd0, 1'(i == 8), 1'b0, 1'b0);
        check("t5_error_latency", 32'(frame_error), 32'd1);
        wait_idle(50);

        // Back-pressure hold, then abort by new SOC during DRAIN
        rx_ready = 1'b0;
        soc();
        byte_in(8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h22, 3'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check("t6_hold_valid", 32'(rx_valid), 32'd1);
            check("t6_hold_data",  32'(rx_data),  32'h11);
            check("t6_hold_last",  32'(rx_last),  32'd0);
            @(posedge clk); #1;
        end
        soc();
        check("t6_abort_pulse", 32'(rx_abort), 32'd1);
        check("t6_busy_after_abort", 32'(busy), 32'd1);
        check("t6_valid_after_abort", 32'(rx_valid), 32'd0);
        rx_ready = 1'b1;
        expect_byte(8'h33, 3'd0, 1'b0);
        expect_byte(8'h44, 3'd0, 1'b0);
        expect_byte(8'h55, 3'd7, 1'b1);
        len_q.push_back(4'd3);
        byte_in(8'h33, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'h55, 3'd7, 1'b1, 1'b0, 1'b0);
        wait_idle(50);
        check("t6_done_cnt", 32'(done_cnt), 32'd4);
        check("t6_abort_cnt", 32'(abort_cnt), 32'd1);

        // Empty frame
        soc();
        errq.push_back(RxError_EMPTY);
        eoc_only();
        check("t7_error_latency", 32'(frame_error), 32'd1);
        wait_idle(50);

        // Reset in the middle of a frame, then a normal frame
        soc();
        byte_in(8'hAA, 3'd0, 1'b0, 1'b0, 1'b0);
        byte_in(8'hBB, 3'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        soc();
        expect_byte(8'hC3, 3'd0, 1'b1);
        len_q.push_back(4'd1);
        byte_in(8'hC3, 3'd0, 1'b1, 1'b0, 1'b0);
        check("t8_valid_latency", 32'(rx_valid), 32'd1);
        wait_idle(50);
        check("t8_done_cnt", 32'(done_cnt), 32'd5);

        check("end_xfer_queue_empty",  32'(exp_q.size()), 32'd0);
        check("end_len_queue_empty",   32'(len_q.size()), 32'd0);
        check("end_error_queue_empty", 32'(errq.size()),  32'd0);
        check("end_error_cnt",         32'(err_cnt),      32'd4);
        check("end_abort_cnt",         32'(abort_cnt),    32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
